mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5, multiply latency in cycles (legal range 1..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  op request, sampled only when idle.
REQ-005 SHALL have port op  input  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU.
REQ-006 SHALL have port src_a  input  32  multiplicand / dividend / MTHI-MTLO data.
REQ-007 SHALL have port src_b  input  32  multiplier / divisor.
REQ-008 SHALL have port mthilo  input  2  01 = write LO, 10 = write HI, 00 and 11 = none.
REQ-009 SHALL have port hi  output  32  HI register.
REQ-010 SHALL have port lo  output  32  LO register.
REQ-011 SHALL have port busy  output  1  registered; high while an op is in flight.
REQ-012 SHALL have port done  output  1  registered one-cycle pulse on the cycle HI/LO take a result.

Function
REQ-013 SHALL use FSM states IDLE, MUL_WAIT, DIV_ITER, DIV_FIX; reset state IDLE.
REQ-014 SHALL, in IDLE with start=1 and a legal nonzero op, latch operands and op at that edge and raise busy from the next cycle.
REQ-015 SHALL hold busy high for exactly MUL_LAT cycles for ops 1, 2, 5-8, then write HI/LO and pulse done in the first cycle busy is low.
REQ-016 SHALL hold busy high for exactly 33 cycles for ops 3-4: 32 radix-2 restoring iterations in DIV_ITER, plus one sign-correction cycle in DIV_FIX.
REQ-017 SHALL form a 64-bit product {HI,LO}: signed for MULT/MADD/MSUB, unsigned for MULTU/MADDU/MSUBU.
REQ-018 SHALL make MADD* {HI,LO} += product and MSUB* {HI,LO} -= product, modulo 2^64, using HI/LO as sampled at start.
REQ-019 SHALL make DIV/DIVU LO = quotient and HI = remainder; signed quotient truncates toward zero, and the remainder takes the sign of the dividend.
REQ-020 SHALL, on divisor zero, produce LO=32'hFFFF_FFFF and HI=src_a after the full 33-cycle latency.
REQ-021 SHALL, on DIV 32'h8000_0000 / 32'hFFFF_FFFF, produce LO=32'h8000_0000 and HI=0.
REQ-022 SHALL ignore start and mthilo while busy; the pipeline stalls, and HI/LO stay stable until the result write.
REQ-023 SHALL, in IDLE, apply mthilo at the edge; HI/LO are visible next cycle, with no busy and no done.
REQ-024 SHALL give start with a legal op precedence over mthilo in the same cycle; mthilo is then dropped.
REQ-025 SHALL treat start with op 0 or op >8 as a NOP: no state change.

Reset
REQ-026 SHALL, with reset=0 at a rising edge, force hi=0, lo=0, busy=0, done=0, state IDLE, and clear the iteration counter.
REQ-027 SHALL, on reset mid-operation, abort the op with no partial HI/LO write; start is ignored during reset.

Configuration
REQ-028 SHALL with MDU_MADD_EN defined support ops 5-8 per REQ-015/REQ-018.
REQ-029 SHALL without MDU_MADD_EN treat ops 5-8 as NOP per REQ-025 and synthesize no accumulate adder.

Structure
REQ-030 SHALL place op encodings, mthilo encodings, the FSM state enum, and DIV_CYCLES=33 in shared package mdu_pkg.
REQ-031 SHALL implement the divider datapath (shift/subtract, 32-cycle counter, magnitude conversion) as sub-module mdu_div_core; the multiply path and FSM stay in mdu_iter.

Verification
REQ-032 SHALL cover: MULT src_a=32'hFFFF_FFFE, src_b=3, MUL_LAT=5 -> busy 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA, done one cycle.
REQ-033 SHALL cover: DIV src_a=-7, src_b=2 -> busy 33 cycles; LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU 7/2 -> LO=3, HI=1.
REQ-034 SHALL cover: DIVU 5/0 -> after 33 cycles LO=32'hFFFF_FFFF, HI=5; DIV 0x8000_0000/-1 -> LO=0x8000_0000, HI=0.
REQ-035 SHALL cover: mthilo=10 with src_a=0x1234 in IDLE -> HI=0x1234 next cycle; the same request while busy -> HI unchanged.
REQ-036 SHALL cover: reset=0 at cycle 10 of a DIV -> next cycle busy=0, HI=LO=0, no done pulse.
REQ-037 SHALL cover, with MDU_MADD_EN defined: HI=0, LO=0xFFFF_FFFF, MADDU 1*1 -> HI=1, LO=0. Without MDU_MADD_EN: same stimulus -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by MDU_MADD_EN.
package mdu_pkg;

  // Total divide latency: 32 restoring iterations + 1 sign-fix cycle
  localparam int DIV_CYCLES = 33;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8
  } mdu_op_e;

  localparam logic [1:0] MTHILO_NONE = 2'b00;
  localparam logic [1:0] MTHILO_LO   = 2'b01;
  localparam logic [1:0] MTHILO_HI   = 2'b10;
  localparam logic [1:0] MTHILO_BOTH = 2'b11;  // treated as no write

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    DIV_ITER,
    DIV_FIX
  } mdu_state_e;

  // Ops accepted in IDLE; anything else is a NOP
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Two's-complement magnitude; 0x8000_0000 maps to itself (correct as unsigned)
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Radix-2 restoring divider: magnitude conversion at load, one quotient bit
// per step, sign correction and divide-by-zero override on the outputs.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        last_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic [31:0] quo_q, quo_d;     // dividend shifts out, quotient shifts in
  logic [31:0] rem_q, rem_d;     // partial remainder (magnitude)
  logic [31:0] dvsr_q, dvsr_d;   // divisor magnitude
  logic [31:0] dvnd_q, dvnd_d;   // raw dividend, returned on divide-by-zero
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [32:0] trial, diff;

  // Load operands or perform one shift/subtract step
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    dvnd_d = dvnd_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    trial  = {rem_q, quo_q[31]};
    // trial < 2*divisor, so a non-negative difference always fits in 32 bits
    diff   = trial - {1'b0, dvsr_q};
    if (load_i) begin
      dvnd_d = dividend_i;
      dvsr_d = mag32(divisor_i, signed_i);
      quo_d  = mag32(dividend_i, signed_i);
      rem_d  = '0;
      cnt_d  = '0;
      qneg_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
      rneg_d = signed_i & dividend_i[31];
      dz_d   = (divisor_i == '0);
    end else if (step_i) begin
      cnt_d = cnt_q + 5'd1;
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      dvnd_q <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
      dvnd_q <= dvnd_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

  // Final iteration is the one before the sign-fix cycle
  assign last_o = (cnt_q == 5'(DIV_CYCLES - 2));

  // Signed overflow (0x8000_0000 / -1) needs no special case: both negative,
  // so the magnitude quotient 0x8000_0000 passes through unnegated.
  assign quo_o = dz_q ? 32'hFFFF_FFFF : (qneg_q ? (~quo_q + 32'd1) : quo_q);
  assign rem_o = dz_q ? dvnd_q        : (rneg_q ? (~rem_q + 32'd1) : rem_q);

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// Fixed-latency multiply (MUL_LAT cycles), 33-cycle restoring divide.
// Define MDU_MADD_EN to add the accumulate ops MADD/MADDU/MSUB/MSUBU.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  mthilo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        div_load, div_step, div_last;
  logic [31:0] div_quo, div_rem;
  logic        mul_sgn;
  logic [63:0] ext_a, ext_b, prod, mul_res;

  // Sign-extending both operands to 64 bits makes the low 64 bits of the
  // product correct for signed and unsigned alike.
  assign mul_sgn = op_is_signed(op_q);
  assign ext_a   = {{32{mul_sgn & a_q[31]}}, a_q};
  assign ext_b   = {{32{mul_sgn & b_q[31]}}, b_q};
  assign prod    = ext_a * ext_b;

`ifdef MDU_MADD_EN
  // Accumulate into HI/LO; they cannot change while busy, so these are
  // still the values present at start.
  always_comb begin
    mul_res = prod;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi_q, lo_q} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi_q, lo_q} - prod;
      default:           mul_res = prod;
    endcase
  end
`else
  assign mul_res = prod;
`endif

  mdu_div_core u_div (
    .clk        (clk),
    .rst_ni     (reset),
    .load_i     (div_load),
    .step_i     (div_step),
    .signed_i   (op_is_signed(op)),
    .dividend_i (src_a),
    .divisor_i  (src_b),
    .last_o     (div_last),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  // Next-state, operand capture, HI/LO writes and status outputs
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcnt_d   = mcnt_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && op_legal(op)) begin
          // start wins over a simultaneous mthilo
          op_d   = op;
          a_d    = src_a;
          b_d    = src_b;
          mcnt_d = '0;
          if (op_is_div(op)) begin
            div_load = 1'b1;
            state_d  = DIV_ITER;
          end else begin
            state_d  = MUL_WAIT;
          end
        end else begin
          case (mthilo)
            MTHILO_LO:   lo_d = src_a;
            MTHILO_HI:   hi_d = src_a;
            MTHILO_NONE, MTHILO_BOTH: ;
            default: ;
          endcase
        end
      end
      MUL_WAIT: begin
        if (mcnt_q == 4'(MUL_LAT - 1)) begin
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          mcnt_d = mcnt_q + 4'd1;
        end
      end
      DIV_ITER: begin
        div_step = 1'b1;
        if (div_last) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        hi_d    = div_rem;
        lo_d    = div_quo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any op without a HI/LO write
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcnt_q  <= mcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, hand-written
// corner sequences, and randomized ops against a behavioural model.
module tb_mdu_iter;

  localparam int MUL_LAT_TB = 5;
  localparam int DIV_LAT    = 33;
`ifdef MDU_MADD_EN
  localparam int NUM_OPS = 8;
`else
  localparam int NUM_OPS = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [1:0]  mthilo = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  // model copies of HI/LO
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  mdu_iter #(.MUL_LAT(MUL_LAT_TB)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .mthilo (mthilo),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural result from the op definitions using wide integer arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    p  = '0;
    case (o)
      4'd1, 4'd5, 4'd7: p = 64'(sa * sb);
      4'd2, 4'd6, 4'd8: p = ua * ub;
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        qv = 64'(q); rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        qv = ua / ub; rv = ua % ub;
        return {rv[31:0], qv[31:0]};
      end
      default: p = acc;
    endcase
    case (o)
      4'd5, 4'd6: return acc + p;
      4'd7, 4'd8: return acc - p;
      default:    return p;
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'($urandom_range(0, 20));
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic write_hilo(input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk);
    mthilo = sel; src_a = d; start = 1'b0;
    @(negedge clk);
    mthilo = 2'b00; src_a = '0;
    if (sel == 2'b10) mhi = d;
    if (sel == 2'b01) mlo = d;
  endtask

  // Issue one op, count busy cycles, check done pulse, HI/LO stability and result.
  // With noise set, start/mthilo are toggled randomly while busy.
  task automatic run_and_check(input string nm, input logic [3:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int exp_lat,
                               input logic [31:0] ehi, input logic [31:0] elo,
                               input bit noise);
    int          bc;
    logic        stable;
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    stable = 1'b1;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; mthilo = 2'b00;
    @(negedge clk);
    start = 1'b0; op = '0; src_a = '0; src_b = '0;
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        op     = 4'($urandom_range(1, 8));
        mthilo = 2'($urandom_range(0, 3));
        src_a  = 32'($urandom);
      end
      @(negedge clk);
      start = 1'b0; mthilo = 2'b00; op = '0; src_a = '0;
    end
    chk({nm, " busy cycles"}, 64'(bc), 64'(exp_lat));
    chk({nm, " hilo stable while busy"}, 64'(stable), 64'd1);
    chk({nm, " done pulse"}, 64'(done), (exp_lat > 0) ? 64'd1 : 64'd0);
    chk({nm, " hi"}, 64'(hi), 64'(ehi));
    chk({nm, " lo"}, 64'(lo), 64'(elo));
    @(negedge clk);
    chk({nm, " done drops"}, 64'(done), 64'd0);
    mhi = ehi; mlo = elo;
  endtask

  vec_t vecs[8];

  initial begin
    int          bc, dones;
    logic [3:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;

    vecs[0] = '{"mult neg2x3",   4'd1, 32'hFFFF_FFFE, 32'd3,         MUL_LAT_TB, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{"div -7/2",      4'd3, 32'hFFFF_FFF9, 32'd2,         DIV_LAT,    32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2] = '{"divu 7/2",      4'd4, 32'd7,         32'd2,         DIV_LAT,    32'd1,         32'd3};
    vecs[3] = '{"divu 5/0",      4'd4, 32'd5,         32'd0,         DIV_LAT,    32'd5,         32'hFFFF_FFFF};
    vecs[4] = '{"div min/-1",    4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,    32'd0,         32'h8000_0000};
    vecs[5] = '{"multu max^2",   4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT_TB, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6] = '{"div 7/-2",      4'd3, 32'd7,         32'hFFFF_FFFE, DIV_LAT,    32'd1,         32'hFFFF_FFFD};
    vecs[7] = '{"div -8/0",      4'd3, 32'hFFFF_FFF8, 32'd0,         DIV_LAT,    32'hFFFF_FFF8, 32'hFFFF_FFFF};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    reset = 1'b1;

    // directed vector table
    for (int i = 0; i < 8; i++)
      run_and_check(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
                    vecs[i].hi, vecs[i].lo, 1'b0);

    // mthilo in IDLE: visible next cycle, no busy, no done
    write_hilo(2'b10, 32'h1234);
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    write_hilo(2'b01, 32'hABCD);
    chk("mtlo lo", 64'(lo), 64'hABCD);
    chk("mtlo hi kept", 64'(hi), 64'h1234);
    @(negedge clk); mthilo = 2'b11; src_a = 32'h5555;
    @(negedge clk); mthilo = 2'b00; src_a = '0;
    chk("mthilo 11 hi", 64'(hi), 64'h1234);
    chk("mthilo 11 lo", 64'(lo), 64'hABCD);

    // mthilo while busy is ignored
    @(negedge clk); start = 1'b1; op = 4'd4; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk); start = 1'b0; op = '0; src_a = '0; src_b = '0;
    mthilo = 2'b10; src_a = 32'hDEAD;
    @(negedge clk); mthilo = 2'b00; src_a = '0;
    chk("mthi while busy hi", 64'(hi), 64'h1234);
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin bc++; @(negedge clk); end
    chk("divu 100/7 busy remaining", 64'(bc), 64'(DIV_LAT - 1));
    chk("divu 100/7 hi", 64'(hi), 64'd2);
    chk("divu 100/7 lo", 64'(lo), 64'd14);

    // start with legal op beats simultaneous mthilo
    write_hilo(2'b10, 32'h1234);
    @(negedge clk); start = 1'b1; op = 4'd2; src_a = 32'd2; src_b = 32'd3; mthilo = 2'b10;
    @(negedge clk); start = 1'b0; op = '0; src_a = '0; src_b = '0; mthilo = 2'b00;
    chk("start+mthi busy", 64'(busy), 64'd1);
    chk("start+mthi hi dropped", 64'(hi), 64'h1234);
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin bc++; @(negedge clk); end
    chk("start+mthi hi result", 64'(hi), 64'd0);
    chk("start+mthi lo result", 64'(lo), 64'd6);
    mhi = 32'd0; mlo = 32'd6;

    // accumulate op (or NOP when the feature is absent)
    write_hilo(2'b10, 32'd0);
    write_hilo(2'b01, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_and_check("maddu 1*1", 4'd6, 32'd1, 32'd1, MUL_LAT_TB, 32'd1, 32'd0, 1'b0);
`else
    run_and_check("maddu nop", 4'd6, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF, 1'b0);
`endif

    // illegal ops are NOPs
    run_and_check("nop op0",  4'd0,  32'd9, 32'd9, 0, mhi, mlo, 1'b0);
    run_and_check("nop op9",  4'd9,  32'd9, 32'd9, 0, mhi, mlo, 1'b0);
    run_and_check("nop op15", 4'd15, 32'd9, 32'd9, 0, mhi, mlo, 1'b0);

    // reset in cycle 10 of a divide: abort, clear, no done
    write_hilo(2'b10, 32'h7777);
    write_hilo(2'b01, 32'h8888);
    @(negedge clk); start = 1'b1; op = 4'd3; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    @(negedge clk); start = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (9) @(negedge clk);
    chk("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b0; start = 1'b1; op = 4'd1; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    chk("mid reset busy", 64'(busy), 64'd0);
    chk("mid reset hi", 64'(hi), 64'd0);
    chk("mid reset lo", 64'(lo), 64'd0);
    chk("mid reset done", 64'(done), 64'd0);
    reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    dones = 0; bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (busy === 1'b1) bc++;
    end
    chk("post reset done pulses", 64'(dones), 64'd0);
    chk("post reset busy cycles", 64'(bc), 64'd0);
    mhi = '0; mlo = '0;

    // randomized ops against the model, with noise on start/mthilo while busy
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        write_hilo(2'b10, 32'($urandom));
        write_hilo(2'b01, 32'($urandom));
      end
      o = 4'($urandom_range(1, NUM_OPS));
      a = rnd32();
      b = rnd32();
      exp = ref_result(o, a, b, {mhi, mlo});
      run_and_check($sformatf("rand%0d op%0d", i, o), o, a, b,
                    (o == 4'd3 || o == 4'd4) ? DIV_LAT : MUL_LAT_TB,
                    exp[63:32], exp[31:0], 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
